// File: rtl/cmd_exec_if.sv
// ---------------------------------------------------------------------------
// cmd_exec_if
// Bundle between the command-memory writer (master) and the execution stage
// cmd_exec_sync (slave).
//
// Handshake: DATA_WR is a one-cycle strobe with no back-pressure.
// All command fields are valid in the strobe cycle only. The slave
// acknowledges consumption of a command by holding REQ_COMM high for
// REQ_LEN cycles. The writer then deletes the executed command and may
// strobe the next one.
//
// Signals:
//   TIME                  system time, one LSB per CLK (master -> slave)
//   DATA_WR + fields      command strobe and command word (master -> slave)
//   ABORT                 abort request, only with CMD_ABORT_EN defined
//   REQ_COMM              next-command request (slave -> master)
//   IMP_OUT, BLANK        transmit/receive gates (slave -> master)
//   NCO_FREQ, NCO_LOAD    synthesiser loader (slave -> master)
//   BUSY, CMD_LATE        status (slave -> master)
// ---------------------------------------------------------------------------
interface cmd_exec_if;
    logic [63:0] TIME;
    logic        DATA_WR;
    logic [47:0] FREQ;
    logic [47:0] FREQ_STEP;
    logic [31:0] FREQ_RATE;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [1:0]  TYPE_impulse;
    logic [31:0] Interval_Ti;
    logic [31:0] Interval_Tp;
    logic [31:0] Tblank1;
    logic [31:0] Tblank2;
`ifdef CMD_ABORT_EN
    logic        ABORT;
`endif
    logic        REQ_COMM;
    logic        IMP_OUT;
    logic        BLANK;
    logic [47:0] NCO_FREQ;
    logic        NCO_LOAD;
    logic        BUSY;
    logic        CMD_LATE;

    modport master (
        output TIME, DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START,
               N_impulse, TYPE_impulse, Interval_Ti, Interval_Tp,
               Tblank1, Tblank2,
`ifdef CMD_ABORT_EN
               ABORT,
`endif
        input  REQ_COMM, IMP_OUT, BLANK, NCO_FREQ, NCO_LOAD, BUSY, CMD_LATE
    );

    modport slave (
        input  TIME, DATA_WR, FREQ, FREQ_STEP, FREQ_RATE, TIME_START,
               N_impulse, TYPE_impulse, Interval_Ti, Interval_Tp,
               Tblank1, Tblank2,
`ifdef CMD_ABORT_EN
               ABORT,
`endif
        output REQ_COMM, IMP_OUT, BLANK, NCO_FREQ, NCO_LOAD, BUSY, CMD_LATE
    );
endinterface

// File: rtl/cmd_exec_sync.sv
// ---------------------------------------------------------------------------
// cmd_exec_sync
// Execution stage for the command-memory writer. A command is captured on
// DATA_WR into a one-deep pending slot and moved to the active registers
// when the stage is idle. The stage waits for TIME to reach TIME_START and
// then plays out:
//   * the leading blank,
//   * N impulses (pulse + gap) with the per-impulse frequency law,
//   * the trailing blank,
//   * a REQ_COMM pulse.
//
// Parameters:
//   REQ_LEN  REQ_COMM high time in cycles (>= 3)
//   CNT_W    width of the interval/blank down-counter
//
// Ports:
//   CLK          clock
//   rst          synchronous active-high reset
//   bus          cmd_exec_if.slave (command in, gates/NCO/status out)
//   dbg_state_o  current FSM state encoding
//
// Optional feature: define CMD_ABORT_EN to add bus.ABORT. ABORT in any
// state other than IDLE/REQ jumps to REQ; a pending command is kept.
// ---------------------------------------------------------------------------
module cmd_exec_sync #(
    parameter int unsigned REQ_LEN = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic           CLK,
    input  logic           rst,
    cmd_exec_if.slave      bus,
    output logic [2:0]     dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_BLANK1 = 3'd2,
        S_PULSE  = 3'd3,
        S_GAP    = 3'd4,
        S_BLANK2 = 3'd5,
        S_REQ    = 3'd6
    } state_t;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] step;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        imp_cnt_q, imp_cnt_d;
    logic [31:0]        rate_cnt_q, rate_cnt_d;
    cmd_t               act_q, act_d;
    cmd_t               pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               first_q, first_d;
    logic [47:0]        nco_freq_q, nco_freq_d;
    logic               nco_load_q, nco_load_d;
    logic               late_q, late_d;

    cmd_t               bus_cmd;
    logic [31:0]        tw;
    logic [31:0]        gap;
    state_t             b2_st, pl_st, b1_st;
    logic [CNT_W-1:0]   b2_cnt, pl_cnt, b1_cnt;
    logic               start_imp;
    logic               chirp_up, chirp_dn;

    assign bus_cmd.freq   = bus.FREQ;
    assign bus_cmd.step   = bus.FREQ_STEP;
    assign bus_cmd.rate   = bus.FREQ_RATE;
    assign bus_cmd.tstart = bus.TIME_START;
    assign bus_cmd.n      = bus.N_impulse;
    assign bus_cmd.typ    = bus.TYPE_impulse;
    assign bus_cmd.ti     = bus.Interval_Ti;
    assign bus_cmd.tp     = bus.Interval_Tp;
    assign bus_cmd.tb1    = bus.Tblank1;
    assign bus_cmd.tb2    = bus.Tblank2;

    // Effective pulse width is at least one cycle.
    // Gap fills the rest of the period, or is zero for back-to-back pulses.
    assign tw  = (act_q.ti == 32'd0) ? 32'd1 : act_q.ti;
    assign gap = (act_q.tp > tw) ? (act_q.tp - tw) : 32'd0;

    // Entry points of each phase with zero-length phases folded away:
    // b1 -> pulses -> b2 -> REQ.
    assign b2_st  = (act_q.tb2 != 32'd0) ? S_BLANK2 : S_REQ;
    assign b2_cnt = (act_q.tb2 != 32'd0) ? CNT_W'(act_q.tb2) : CNT_W'(REQ_LEN);
    assign pl_st  = (act_q.n == 16'd0) ? b2_st : S_PULSE;
    assign pl_cnt = (act_q.n == 16'd0) ? b2_cnt : CNT_W'(tw);
    assign b1_st  = (act_q.tb1 != 32'd0) ? S_BLANK1 : pl_st;
    assign b1_cnt = (act_q.tb1 != 32'd0) ? CNT_W'(act_q.tb1) : pl_cnt;

    assign chirp_up = (act_q.typ == 2'b01);
    assign chirp_dn = (act_q.typ == 2'b10);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        imp_cnt_d   = imp_cnt_q;
        rate_cnt_d  = rate_cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        first_d     = 1'b0;
        nco_freq_d  = nco_freq_q;
        nco_load_d  = 1'b0;
        late_d      = 1'b0;
        start_imp   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_full_q) begin
                    act_d       = pend_q;
                    pend_full_d = 1'b0;
                    first_d     = 1'b1;
                    state_d     = S_ARMED;
                end
            end
            S_ARMED: begin
                imp_cnt_d = 16'd0;
                if (bus.DATA_WR) begin
                    // A newer command replaces the armed one and restarts the search.
                    act_d   = bus_cmd;
                    first_d = 1'b1;
                end else if (first_q && (act_q.tstart < bus.TIME)) begin
                    late_d  = 1'b1;
                    state_d = S_REQ;
                    cnt_d   = CNT_W'(REQ_LEN);
                end else if (bus.TIME >= act_q.tstart) begin
                    state_d = b1_st;
                    cnt_d   = b1_cnt;
                end
            end
            S_BLANK1: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = pl_st;
                    cnt_d   = pl_cnt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == CNT_W'(1)) begin
                    imp_cnt_d = imp_cnt_q + 16'd1;
                    if (gap != 32'd0) begin
                        state_d = S_GAP;
                        cnt_d   = CNT_W'(gap);
                    end else if ((imp_cnt_q + 16'd1) == act_q.n) begin
                        state_d = b2_st;
                        cnt_d   = b2_cnt;
                    end else begin
                        state_d = S_PULSE;
                        cnt_d   = CNT_W'(tw);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (imp_cnt_q == act_q.n) begin
                        state_d = b2_st;
                        cnt_d   = b2_cnt;
                    end else begin
                        state_d = S_PULSE;
                        cnt_d   = CNT_W'(tw);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BLANK2: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_REQ;
                    cnt_d   = CNT_W'(REQ_LEN);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_REQ: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes outside ARMED always land in the pending slot.
        // This also covers IDLE, where the slot was just emptied above.
        if (bus.DATA_WR && (state_q != S_ARMED)) begin
            pend_d      = bus_cmd;
            pend_full_d = 1'b1;
        end

`ifdef CMD_ABORT_EN
        if (bus.ABORT && (state_q != S_IDLE) && (state_q != S_REQ)) begin
            state_d = S_REQ;
            cnt_d   = CNT_W'(REQ_LEN);
            late_d  = 1'b0;
            act_d   = act_q;
            if (bus.DATA_WR && (state_q == S_ARMED)) begin
                pend_d      = bus_cmd;
                pend_full_d = 1'b1;
            end
        end
`endif

        // A new impulse starts on any entry into PULSE except the
        // continuation of a pulse that still has cycles left.
        start_imp = (state_d == S_PULSE) &&
                    !((state_q == S_PULSE) && (cnt_q != CNT_W'(1)));

        if (start_imp) begin
            nco_freq_d = act_q.freq;
            nco_load_d = 1'b1;
            rate_cnt_d = 32'd1;
        end else if ((state_q == S_PULSE) && (state_d == S_PULSE)) begin
            // rate_cnt counts the cycles the current word has been shown.
            if ((act_q.rate != 32'd0) && (rate_cnt_q == act_q.rate)) begin
                rate_cnt_d = 32'd1;
                if (chirp_up) begin
                    nco_freq_d = nco_freq_q + act_q.step;
                    nco_load_d = 1'b1;
                end else if (chirp_dn) begin
                    nco_freq_d = nco_freq_q - act_q.step;
                    nco_load_d = 1'b1;
                end
            end else begin
                rate_cnt_d = rate_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            imp_cnt_q   <= '0;
            rate_cnt_q  <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            first_q     <= 1'b0;
            nco_freq_q  <= '0;
            nco_load_q  <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            imp_cnt_q   <= imp_cnt_d;
            rate_cnt_q  <= rate_cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            first_q     <= first_d;
            nco_freq_q  <= nco_freq_d;
            nco_load_q  <= nco_load_d;
            late_q      <= late_d;
        end
    end

    assign bus.REQ_COMM = (state_q == S_REQ);
    assign bus.IMP_OUT  = (state_q == S_PULSE);
    assign bus.BLANK    = (state_q == S_BLANK1) || (state_q == S_BLANK2);
    assign bus.BUSY     = (state_q != S_IDLE);
    assign bus.NCO_FREQ = nco_freq_q;
    assign bus.NCO_LOAD = nco_load_q;
    assign bus.CMD_LATE = late_q;
    assign dbg_state_o  = state_q;

endmodule
